// File: rtl/dpram_rr_arbiter.sv
// Round-robin sharing of one dual-port RAM (write port A, read port B) between two
// writers and two readers, with per-reader valid returned after the RAM read latency.
module dpram_rr_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 14,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          w0_req,
    input  logic [AW-1:0] w0_addr,
    input  logic [DW-1:0] w0_data,
    output logic          w0_gnt,
    input  logic          w1_req,
    input  logic [AW-1:0] w1_addr,
    input  logic [DW-1:0] w1_data,
    output logic          w1_gnt,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_gnt,
    output logic          r0_vld,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_gnt,
    output logic          r1_vld,
    output logic [DW-1:0] r_data,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob
);

    // Handshake: a requester holds req/addr/data until it sees gnt high in a cycle;
    // that clock edge commits the access. An ungranted request simply retries.
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               w_win, r_win, r_gnt_any, inflight;
    logic [N_DELAY-1:0] tag_vld_q, tag_vld_d;
    logic [N_DELAY-1:0] tag_id_q, tag_id_d;

    always_comb begin : write_arb
        w0_gnt    = rstn & w0_req & (~w1_req | ~wr_ptr_q);
        w1_gnt    = rstn & w1_req & (~w0_req | wr_ptr_q);
        w_win     = w1_gnt | (~w0_gnt & wr_ptr_q);
        ram_ena   = w0_gnt | w1_gnt;
        ram_wea   = ram_ena;
        ram_addra = w_win ? w1_addr : w0_addr;
        ram_dia   = w_win ? w1_data : w0_data;
        wr_ptr_d  = wr_ptr_q;
        if (w0_gnt) begin
            wr_ptr_d = 1'b1;
        end else if (w1_gnt) begin
            wr_ptr_d = 1'b0;
        end
    end

    always_comb begin : read_arb
        r0_gnt    = rstn & r0_req & (~r1_req | ~rd_ptr_q);
        r1_gnt    = rstn & r1_req & (~r0_req | rd_ptr_q);
        r_win     = r1_gnt | (~r0_gnt & rd_ptr_q);
        r_gnt_any = r0_gnt | r1_gnt;
        ram_addrb = r_win ? r1_addr : r0_addr;
        rd_ptr_d  = rd_ptr_q;
        if (r0_gnt) begin
            rd_ptr_d = 1'b1;
        end else if (r1_gnt) begin
            rd_ptr_d = 1'b0;
        end
    end

    // The RAM delay chain only advances with enb, so enb stays high while any read
    // has yet to reach the last stage. With enb low nothing is in the early stages and
    // the last stage has already been presented, so clearing all valids is safe.
    always_comb begin : tag_pipe
        inflight = 1'b0;
        for (int i = 0; i < N_DELAY - 1; i++) begin
            inflight = inflight | tag_vld_q[i];
        end
        ram_enb   = r_gnt_any | inflight;
        tag_vld_d = '0;
        tag_id_d  = tag_id_q;
        if (ram_enb) begin
            tag_vld_d[0] = r_gnt_any;
            tag_id_d[0]  = r_win;
            for (int i = 1; i < N_DELAY; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
        end
    end

    assign r0_vld = tag_vld_q[N_DELAY-1] & ~tag_id_q[N_DELAY-1];
    assign r1_vld = tag_vld_q[N_DELAY-1] & tag_id_q[N_DELAY-1];
    assign r_data = ram_dob;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: two instances (read latency 1 and 3) share stimulus,
// each backed by a small RAM model and checked against a transaction-level model.
module tb_dpram_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          w0_req, w1_req, r0_req, r1_req;
    logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
    logic [DW-1:0] w0_data, w1_data;

    logic          w0_gnt_o [2];
    logic          w1_gnt_o [2];
    logic          r0_gnt_o [2];
    logic          r1_gnt_o [2];
    logic          r0_vld_o [2];
    logic          r1_vld_o [2];
    logic          ram_ena_o [2];
    logic          ram_wea_o [2];
    logic          ram_enb_o [2];
    logic [AW-1:0] ram_addra_o [2];
    logic [AW-1:0] ram_addrb_o [2];
    logic [DW-1:0] ram_dia_o [2];
    logic [DW-1:0] r_data_o [2];
    logic [DW-1:0] ram_dob_i [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs and RAM models ----------------
    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int ND = (k == 0) ? 1 : 3;
        logic [DW-1:0] mem   [16];
        logic [DW-1:0] chain [ND];

        dpram_rr_arbiter #(.DW(DW), .AW(AW), .N_DELAY(ND)) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .w0_req    (w0_req),
            .w0_addr   (w0_addr),
            .w0_data   (w0_data),
            .w0_gnt    (w0_gnt_o[k]),
            .w1_req    (w1_req),
            .w1_addr   (w1_addr),
            .w1_data   (w1_data),
            .w1_gnt    (w1_gnt_o[k]),
            .r0_req    (r0_req),
            .r0_addr   (r0_addr),
            .r0_gnt    (r0_gnt_o[k]),
            .r0_vld    (r0_vld_o[k]),
            .r1_req    (r1_req),
            .r1_addr   (r1_addr),
            .r1_gnt    (r1_gnt_o[k]),
            .r1_vld    (r1_vld_o[k]),
            .r_data    (r_data_o[k]),
            .ram_ena   (ram_ena_o[k]),
            .ram_wea   (ram_wea_o[k]),
            .ram_addra (ram_addra_o[k]),
            .ram_dia   (ram_dia_o[k]),
            .ram_enb   (ram_enb_o[k]),
            .ram_addrb (ram_addrb_o[k]),
            .ram_dob   (ram_dob_i[k])
        );

        // Read-before-write RAM whose read chain advances only with enb.
        always @(posedge clk) begin
            if (ram_enb_o[k]) begin
                for (int s = ND - 1; s > 0; s--) chain[s] <= chain[s-1];
                chain[0] <= mem[ram_addrb_o[k]];
            end
            if (ram_ena_o[k] && ram_wea_o[k]) mem[ram_addra_o[k]] <= ram_dia_o[k];
        end
        assign ram_dob_i[k] = chain[ND-1];
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Reads are transactions due back a fixed number of cycles after their grant;
    // data is taken from the model memory before that cycle's write lands.
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend_q [2][$];
    logic [DW-1:0] mdl_mem [16];
    int            wpref = 0;
    int            rpref = 0;
    logic          ew0 = 1'b0, ew1 = 1'b0, er0 = 1'b0, er1 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d%0d.rst_w_gnt", k), {w0_gnt_o[k], w1_gnt_o[k]}, 0);
                chk($sformatf("d%0d.rst_r_gnt", k), {r0_gnt_o[k], r1_gnt_o[k]}, 0);
                chk($sformatf("d%0d.rst_vld", k), {r0_vld_o[k], r1_vld_o[k]}, 0);
                chk($sformatf("d%0d.rst_en", k), {ram_ena_o[k], ram_wea_o[k], ram_enb_o[k]}, 0);
                pend_q[k].delete();
            end
            wpref = 0;
            rpref = 0;
            ew0 = 0; ew1 = 0; er0 = 0; er1 = 0;
        end else begin
            ew0 = w0_req && (!w1_req || wpref == 0);
            ew1 = w1_req && !ew0;
            er0 = r0_req && (!r1_req || rpref == 0);
            er1 = r1_req && !er0;
            for (int k = 0; k < 2; k++) begin
                int            nd;
                logic          ev0, ev1;
                logic [DW-1:0] ed;
                nd  = (k == 0) ? 1 : 3;
                ev0 = 1'b0;
                ev1 = 1'b0;
                ed  = '0;
                if (pend_q[k].size() > 0 && pend_q[k][0].due == cyc) begin
                    ev0 = !pend_q[k][0].id;
                    ev1 = pend_q[k][0].id;
                    ed  = pend_q[k][0].data;
                    void'(pend_q[k].pop_front());
                end
                chk($sformatf("d%0d.w0_gnt", k), w0_gnt_o[k], ew0);
                chk($sformatf("d%0d.w1_gnt", k), w1_gnt_o[k], ew1);
                chk($sformatf("d%0d.r0_gnt", k), r0_gnt_o[k], er0);
                chk($sformatf("d%0d.r1_gnt", k), r1_gnt_o[k], er1);
                chk($sformatf("d%0d.ram_ena", k), ram_ena_o[k], ew0 | ew1);
                chk($sformatf("d%0d.ram_wea", k), ram_wea_o[k], ew0 | ew1);
                chk($sformatf("d%0d.ram_enb", k), ram_enb_o[k], (er0 | er1) || pend_q[k].size() > 0);
                chk($sformatf("d%0d.r0_vld", k), r0_vld_o[k], ev0);
                chk($sformatf("d%0d.r1_vld", k), r1_vld_o[k], ev1);
                if (ev0 || ev1) chk($sformatf("d%0d.r_data", k), r_data_o[k], ed);
                if (ew0 || ew1) begin
                    chk($sformatf("d%0d.ram_addra", k), ram_addra_o[k], ew1 ? w1_addr : w0_addr);
                    chk($sformatf("d%0d.ram_dia", k), ram_dia_o[k], ew1 ? w1_data : w0_data);
                end
                if (er0 || er1) begin
                    chk($sformatf("d%0d.ram_addrb", k), ram_addrb_o[k], er1 ? r1_addr : r0_addr);
                    pend_q[k].push_back('{cyc + nd, er1, mdl_mem[er1 ? r1_addr : r0_addr]});
                end
            end
            if (ew0) mdl_mem[w0_addr] = w0_data;
            else if (ew1) mdl_mem[w1_addr] = w1_data;
            if (ew0) wpref = 1;
            else if (ew1) wpref = 0;
            if (er0) rpref = 1;
            else if (er1) rpref = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0;
        w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
        w0_addr = '0; w1_addr = '0; r0_addr = '0; r1_addr = '0;
        w0_data = '0; w1_data = '0;
        tick();
        tick();
        w0_req = 1; r1_req = 1;
        @(negedge clk);
        chk("rst_w0_gnt_lit", w0_gnt_o[0], 0);
        chk("rst_r1_gnt_lit", r1_gnt_o[1], 0);
        chk("rst_enb_lit", ram_enb_o[1], 0);
        tick();
        rstn = 1'b1;
        r1_req = 0;

        // Fill the whole RAM through w0; addresses 0..3 hold 0xA0..0xA3.
        for (int a = 0; a < 16; a++) begin
            w0_req  = 1;
            w0_addr = AW'(a);
            w0_data = (a < 4) ? DW'(32'hA0 + a) : DW'(32'hB0 + a);
            @(negedge clk);
            if (a < 4) begin
                chk("fill_w0_gnt_lit", w0_gnt_o[0], 1);
                chk("fill_addra_lit", ram_addra_o[0], a);
            end
            tick();
        end
        w0_req = 0;

        // Reset pulse, then alternating grants with both writers busy.
        rstn = 0;
        tick();
        rstn = 1;
        w0_req = 1; w0_addr = 4'd8; w0_data = 32'h1234_0008;
        w1_req = 1; w1_addr = 4'd9; w1_data = 32'h1234_0009;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_w0_lit", w0_gnt_o[0], (i % 2 == 0));
            chk("rr_w1_lit", w1_gnt_o[0], (i % 2 == 1));
            tick();
        end
        w0_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("solo_w1_lit", w1_gnt_o[0], 1);
            tick();
        end
        w1_req = 0;

        // Both readers at once, latency 1.
        r0_req = 1; r0_addr = 4'd1; r1_req = 1; r1_addr = 4'd2;
        @(negedge clk);
        chk("dual_r0_gnt_lit", r0_gnt_o[0], 1);
        chk("dual_r1_gnt_lit", r1_gnt_o[0], 0);
        tick();
        r0_req = 0;
        @(negedge clk);
        chk("dual_r1_gnt2_lit", r1_gnt_o[0], 1);
        chk("dual_r0_vld_lit", r0_vld_o[0], 1);
        chk("dual_r0_data_lit", r_data_o[0], 32'hA1);
        tick();
        r1_req = 0;
        @(negedge clk);
        chk("dual_r1_vld_lit", r1_vld_o[0], 1);
        chk("dual_r1_data_lit", r_data_o[0], 32'hA2);
        tick();
        repeat (4) tick();

        // Single read, latency 3.
        r1_req = 1; r1_addr = 4'd3;
        @(negedge clk);
        chk("lat3_enb0_lit", ram_enb_o[1], 1);
        chk("lat3_gnt_lit", r1_gnt_o[1], 1);
        tick();
        r1_req = 0;
        @(negedge clk);
        chk("lat3_enb1_lit", ram_enb_o[1], 1);
        chk("lat3_novld_lit", r1_vld_o[1], 0);
        tick();
        @(negedge clk);
        chk("lat3_enb2_lit", ram_enb_o[1], 1);
        tick();
        @(negedge clk);
        chk("lat3_enb3_lit", ram_enb_o[1], 0);
        chk("lat3_vld_lit", r1_vld_o[1], 1);
        chk("lat3_data_lit", r_data_o[1], 32'hA3);
        tick();

        // Same-address write and read in one cycle returns the old word.
        w0_req = 1; w0_addr = 4'd0; w0_data = 32'h55;
        r0_req = 1; r0_addr = 4'd0;
        @(negedge clk);
        chk("rw_w0_gnt_lit", w0_gnt_o[0], 1);
        chk("rw_r0_gnt_lit", r0_gnt_o[0], 1);
        tick();
        w0_req = 0;
        @(negedge clk);
        chk("rw_old_vld_lit", r0_vld_o[0], 1);
        chk("rw_old_data_lit", r_data_o[0], 32'hA0);
        tick();
        r0_req = 0;
        @(negedge clk);
        chk("rw_new_data_lit", r_data_o[0], 32'h55);
        tick();
        repeat (4) tick();

        // Reset while a latency-3 read is in flight.
        r0_req = 1; r0_addr = 4'd1;
        @(negedge clk);
        chk("mid_gnt_lit", r0_gnt_o[1], 1);
        tick();
        r0_req = 0;
        rstn = 0;
        tick();
        rstn = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_vld_lit", {r0_vld_o[1], r1_vld_o[1]}, 0);
            tick();
        end
        w0_req = 1; w1_req = 1; r0_req = 1; r1_req = 1;
        w0_addr = 4'd5; w1_addr = 4'd6; r0_addr = 4'd7; r1_addr = 4'd8;
        @(negedge clk);
        chk("post_rst_r0_lit", r0_gnt_o[1], 1);
        chk("post_rst_w0_lit", w0_gnt_o[1], 1);
        tick();

        // Randomized traffic with occasional resets; requests held until granted.
        for (int c = 0; c < 3000; c++) begin
            if (!w0_req || ew0) begin
                w0_req  = ($urandom_range(0, 99) < 60);
                w0_addr = AW'($urandom_range(0, 15));
                w0_data = $urandom;
            end
            if (!w1_req || ew1) begin
                w1_req  = ($urandom_range(0, 99) < 60);
                w1_addr = AW'($urandom_range(0, 15));
                w1_data = $urandom;
            end
            if (!r0_req || er0) begin
                r0_req  = ($urandom_range(0, 99) < 60);
                r0_addr = AW'($urandom_range(0, 15));
            end
            if (!r1_req || er1) begin
                r1_req  = ($urandom_range(0, 99) < 60);
                r1_addr = AW'($urandom_range(0, 15));
            end
            rstn = ($urandom_range(0, 399) != 0);
            tick();
        end
        rstn = 1;
        w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
